calpoc_button_conditioner: RTL and testbench
============================================

CALPOC_BUTTON_CONDITIONER -- requirements
Module: calpoc_button_conditioner

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops per button input (minimum 2).
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized cycles required before the debounced level changes (minimum 1).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 CLK  input  1  system clock; all state updates on its rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 ButtonFor1, ButtonFor0, ButtonForOR, ButtonForXOR, ButtonForEquals, ButtonForClear  input  1 each  raw, asynchronous, bouncy push-button levels (1 = pressed).
REQ-007 PulseFor1, PulseFor0, PulseForOR, PulseForXOR, PulseForEquals, PulseForClear  output  1 each  single-cycle press pulses, consumed by calpoc_fsm button inputs.
REQ-008 Debounced  output  6  debounced levels; bit order {Clear, Equals, XOR, OR, 0, 1}, bit 0 = ButtonFor1.

Function
REQ-009 Each raw input SHALL pass through a SYNC_STAGES-deep flop chain before any other logic uses it.
REQ-010 Each button SHALL have its own stability counter: cleared when the synchronized level equals the debounced level, incremented when it differs.
REQ-011 The debounced level SHALL toggle on the edge where the counter would reach DEBOUNCE_CYCLES; the counter clears on that same edge.
REQ-012 A synchronized deviation shorter than DEBOUNCE_CYCLES cycles SHALL leave the debounced level and the pulses unchanged.
REQ-013 A rising edge of a debounced level SHALL produce a registered pulse exactly one cycle wide, one cycle after the debounced level rises.
REQ-014 Falling edges of the debounced level SHALL produce no pulse.
REQ-015 Total latency from a clean raw rising level (set up before edge 1) to pulse high SHALL be exactly SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges.
REQ-016 The six Pulse outputs SHALL be one-hot-or-zero in every cycle.
REQ-017 When several debounced rising edges occur in the same cycle, only the highest-priority pulse SHALL be emitted; priority order is Clear > Equals > OR > XOR > 1 > 0.
REQ-018 Lower-priority edges that lose arbitration SHALL be dropped, not queued.
REQ-019 A button held indefinitely SHALL produce exactly one pulse; re-press requires a debounced release followed by a new debounced press.
REQ-020 The counter width SHALL be clog2(DEBOUNCE_CYCLES+1), and the counter SHALL never wrap.

Reset
REQ-021 While RST = 1, all synchronizer flops, counters, Debounced and all Pulse outputs SHALL be 0, regardless of CLK.
REQ-022 A button already held when RST deasserts SHALL be treated as a new press and pulse after the REQ-015 latency.
REQ-023 Reset asserted mid-debounce SHALL discard the partial count, and no pulse SHALL follow the deassertion unless the press persists.

Structure
REQ-024 Shared package calpoc_pkg SHALL hold the button index constants (BTN_1=0 .. BTN_CLEAR=5), NUM_BUTTONS=6, and the default DEBOUNCE_CYCLES.
REQ-025 Sub-module calpoc_debounce (synchronizer + counter + debounced level + rise detect, one button) SHALL be instantiated six times; the priority arbiter and output registers reside in the top module.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-026 Clean press: ButtonFor1 high from before edge 1, held for 20 cycles -> PulseFor1 high only in the cycle after edge 7; Debounced[0] = 1 from edge 6.
REQ-027 Bounce: ButtonFor0 toggles 1,0,1,0 every cycle, then stays 1 -> exactly one PulseFor0, 7 edges after the last rising toggle.
REQ-028 Glitch: ButtonForOR high for 3 cycles -> no pulse and Debounced[2] stays 0.
REQ-029 Simultaneous press: ButtonForXOR and ButtonForClear rise together -> one PulseForClear and no PulseForXOR.
REQ-030 Reset mid-debounce: ButtonForEquals held, RST pulsed at edge 4 -> all outputs 0 during reset; PulseForEquals appears 7 edges after RST deasserts.
REQ-031 Sequence 1,0,1,OR,0,0,1,=,Clear, each held 10 cycles with 10-cycle gaps -> nine pulses on the matching outputs, in order, each one cycle wide.

Source files
------------

// File: rtl/calpoc_button_conditioner_pkg.sv
// calpoc_pkg: button indices, shared widths and the press-pulse priority arbiter.
package calpoc_pkg;
  localparam int NUM_BUTTONS = 6;
  localparam int BTN_1 = 0;
  localparam int BTN_0 = 1;
  localparam int BTN_OR = 2;
  localparam int BTN_XOR = 3;
  localparam int BTN_EQUALS = 4;
  localparam int BTN_CLEAR = 5;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
  typedef logic [NUM_BUTTONS-1:0] btn_vec_t;
  localparam btn_vec_t BTN_ONE = btn_vec_t'(1);
  // Losing edges are dropped outright; OR beats XOR and 1 beats 0.
  function automatic btn_vec_t arbitrate(input btn_vec_t rise);
    return rise[BTN_CLEAR]  ? BTN_ONE << BTN_CLEAR  :
           rise[BTN_EQUALS] ? BTN_ONE << BTN_EQUALS :
           rise[BTN_OR]     ? BTN_ONE << BTN_OR     :
           rise[BTN_XOR]    ? BTN_ONE << BTN_XOR    :
           rise[BTN_1]      ? BTN_ONE << BTN_1      :
           rise[BTN_0]      ? BTN_ONE << BTN_0      : '0;
  endfunction
endpackage

// File: rtl/calpoc_button_conditioner_if.sv
// calpoc_button_conditioner_if: raw buttons in, press pulses and debounced levels out.
interface calpoc_button_conditioner_if;
  import calpoc_pkg::*;
  logic ButtonFor1, ButtonFor0, ButtonForOR, ButtonForXOR, ButtonForEquals, ButtonForClear;
  logic PulseFor1, PulseFor0, PulseForOR, PulseForXOR, PulseForEquals, PulseForClear;
  btn_vec_t Debounced;
  modport master (
    output ButtonFor1, ButtonFor0, ButtonForOR, ButtonForXOR, ButtonForEquals, ButtonForClear,
    input PulseFor1, PulseFor0, PulseForOR, PulseForXOR, PulseForEquals, PulseForClear, Debounced
  );
  modport slave (
    input ButtonFor1, ButtonFor0, ButtonForOR, ButtonForXOR, ButtonForEquals, ButtonForClear,
    output PulseFor1, PulseFor0, PulseForOR, PulseForXOR, PulseForEquals, PulseForClear, Debounced
  );
endinterface

// File: rtl/calpoc_button_conditioner_debounce.sv
// calpoc_debounce: one button's synchronizer, stability counter, debounced level and rise detect.
module calpoc_debounce
  import calpoc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic CLK,
  input  logic RST,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic level_q;
  logic synced;
  assign synced = sync[SYNC_STAGES-1];
  // The counter toggles the level on its final count, so it never exceeds DEBOUNCE_CYCLES-1.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync <= '0;
      cnt <= '0;
      level <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      level_q <= level;
      if (synced == level) cnt <= '0;
      else if (cnt == LAST) begin
        cnt <= '0;
        level <= ~level;
      end else cnt <= cnt + 1'b1;
    end
  end
  assign rise = level & ~level_q;
endmodule

// File: rtl/calpoc_button_conditioner.sv
// calpoc_button_conditioner: six debounced buttons arbitrated into one-hot single-cycle press pulses.
module calpoc_button_conditioner
  import calpoc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input logic CLK,
  input logic RST,
  calpoc_button_conditioner_if.slave bus
);
  btn_vec_t raw, level, rise, pulse;
  assign raw = {bus.ButtonForClear, bus.ButtonForEquals, bus.ButtonForXOR,
                bus.ButtonForOR, bus.ButtonFor0, bus.ButtonFor1};
  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    calpoc_debounce #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .CLK(CLK),
      .RST(RST),
      .raw(raw[i]),
      .level(level[i]),
      .rise(rise[i])
    );
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) pulse <= '0;
    else pulse <= arbitrate(rise);
  end
  assign bus.Debounced = level;
  assign {bus.PulseForClear, bus.PulseForEquals, bus.PulseForXOR,
          bus.PulseForOR, bus.PulseFor0, bus.PulseFor1} = pulse;
endmodule

// File: tb/tb_calpoc_button_conditioner.sv
// tb_calpoc_button_conditioner: directed and random presses against a sample-window reference model.
module tb_calpoc_button_conditioner;
  import calpoc_pkg::*;
  localparam int S = 2;
  localparam int D = 4;
  localparam int ORDER[6] = '{BTN_CLEAR, BTN_EQUALS, BTN_OR, BTN_XOR, BTN_1, BTN_0};
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [5:0] raw = 6'h3f;
  logic [5:0] pulses;
  int checks = 0;
  int errors = 0;
  logic [5:0] hist[$];
  logic [5:0] m_deb, m_rise, m_pulse;
  calpoc_button_conditioner_if bus();
  assign {bus.ButtonForClear, bus.ButtonForEquals, bus.ButtonForXOR,
          bus.ButtonForOR, bus.ButtonFor0, bus.ButtonFor1} = raw;
  assign pulses = {bus.PulseForClear, bus.PulseForEquals, bus.PulseForXOR,
                   bus.PulseForOR, bus.PulseFor0, bus.PulseFor1};
  calpoc_button_conditioner #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );
  always #5 CLK = ~CLK;
  task automatic model_reset();
    hist = {};
    for (int i = 0; i < S + D; i++) hist.push_back(6'h00);
    m_deb = '0;
    m_rise = '0;
    m_pulse = '0;
  endtask
  function automatic logic [5:0] pick(input logic [5:0] r);
    for (int k = 0; k < 6; k++) if (r[ORDER[k]]) return 6'd1 << ORDER[k];
    return 6'h00;
  endfunction
  // A level flips once the D raw samples taken S edges ago all disagree with it.
  task automatic step();
    logic [5:0] nd;
    logic all_diff;
    @(posedge CLK);
    hist.push_back(raw);
    void'(hist.pop_front());
    nd = m_deb;
    for (int b = 0; b < 6; b++) begin
      all_diff = 1'b1;
      for (int j = 0; j < D; j++) if (hist[j][b] == m_deb[b]) all_diff = 1'b0;
      if (all_diff) nd[b] = ~m_deb[b];
    end
    m_pulse = pick(m_rise);
    m_rise = nd & ~m_deb;
    m_deb = nd;
    #1;
  endtask
  task automatic quiet(input int n);
    raw = '0;
    repeat (n) step();
  endtask
  task automatic test_reset();
    #2;
    checks++;
    if (pulses !== 6'h00 || bus.Debounced !== 6'h00) begin
      errors++;
      $display("FAIL reset_async: pulse=%b deb=%b expected 000000/000000", pulses, bus.Debounced);
    end
    repeat (3) begin
      @(posedge CLK);
      #1;
      checks++;
      if (pulses !== 6'h00 || bus.Debounced !== 6'h00) begin
        errors++;
        $display("FAIL reset_clocked: pulse=%b deb=%b expected 000000/000000", pulses, bus.Debounced);
      end
    end
    RST = 1'b0;
    model_reset();
    for (int c = 1; c <= 10; c++) begin
      step();
      checks++;
      if (pulses !== (c == 7 ? 6'b100000 : 6'h00) || pulses !== m_pulse || bus.Debounced !== m_deb) begin
        errors++;
        $display("FAIL held_at_reset edge %0d: pulse=%b deb=%b expected pulse=%b deb=%b",
                 c, pulses, bus.Debounced, m_pulse, m_deb);
      end
    end
    quiet(12);
  endtask
  task automatic test_clean_press();
    raw = 6'b000001;
    for (int c = 1; c <= 20; c++) begin
      step();
      checks++;
      if (pulses !== (c == 7 ? 6'b000001 : 6'h00) || bus.Debounced[0] !== (c >= 6)
          || pulses !== m_pulse || bus.Debounced !== m_deb) begin
        errors++;
        $display("FAIL clean_press edge %0d: pulse=%b deb=%b expected pulse=%b deb=%b",
                 c, pulses, bus.Debounced, m_pulse, m_deb);
      end
    end
    quiet(12);
  endtask
  task automatic test_bounce();
    int n = 0;
    int at = 0;
    for (int c = 1; c <= 30; c++) begin
      raw = (c <= 4) ? {4'b0, c[0], 1'b0} : 6'b000010;
      step();
      if (pulses[BTN_0]) begin
        n++;
        at = c;
      end
      checks++;
      if (pulses !== m_pulse || bus.Debounced !== m_deb) begin
        errors++;
        $display("FAIL bounce edge %0d: pulse=%b deb=%b expected pulse=%b deb=%b",
                 c, pulses, bus.Debounced, m_pulse, m_deb);
      end
    end
    checks++;
    if (n != 1 || at != 11) begin
      errors++;
      $display("FAIL bounce_pulse: count=%0d edge=%0d expected count=1 edge=11", n, at);
    end
    quiet(12);
  endtask
  task automatic test_glitch();
    for (int c = 1; c <= 15; c++) begin
      raw = (c <= 3) ? 6'b000100 : 6'h00;
      step();
      checks++;
      if (pulses !== 6'h00 || bus.Debounced[BTN_OR] !== 1'b0 || bus.Debounced !== m_deb) begin
        errors++;
        $display("FAIL glitch edge %0d: pulse=%b deb=%b expected 000000/000000", c, pulses, bus.Debounced);
      end
    end
  endtask
  task automatic test_simultaneous();
    int pa[4] = '{BTN_XOR, BTN_OR, BTN_1, BTN_EQUALS};
    int pb[4] = '{BTN_CLEAR, BTN_XOR, BTN_0, BTN_OR};
    int win[4] = '{BTN_CLEAR, BTN_OR, BTN_1, BTN_EQUALS};
    for (int p = 0; p < 4; p++) begin
      logic [5:0] seen = '0;
      int n = 0;
      raw = (6'd1 << pa[p]) | (6'd1 << pb[p]);
      repeat (15) begin
        step();
        seen |= pulses;
        if (pulses != 0) n++;
        checks++;
        if (pulses !== m_pulse || $countones(pulses) > 1) begin
          errors++;
          $display("FAIL simultaneous pair %0d: pulse=%b expected %b", p, pulses, m_pulse);
        end
      end
      checks++;
      if (n != 1 || seen !== 6'd1 << win[p]) begin
        errors++;
        $display("FAIL simultaneous_winner pair %0d: seen=%b count=%0d expected %b once",
                 p, seen, n, 6'd1 << win[p]);
      end
      quiet(12);
    end
  endtask
  task automatic test_reset_mid();
    raw = 6'b010000;
    repeat (3) step();
    RST = 1'b1;
    model_reset();
    #1;
    checks++;
    if (pulses !== 6'h00 || bus.Debounced !== 6'h00) begin
      errors++;
      $display("FAIL reset_mid_async: pulse=%b deb=%b expected 000000/000000", pulses, bus.Debounced);
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step();
      checks++;
      if (pulses !== (c == 7 ? 6'b010000 : 6'h00) || pulses !== m_pulse || bus.Debounced !== m_deb) begin
        errors++;
        $display("FAIL reset_mid edge %0d: pulse=%b deb=%b expected pulse=%b deb=%b",
                 c, pulses, bus.Debounced, m_pulse, m_deb);
      end
    end
    quiet(12);
  endtask
  task automatic test_sequence();
    int seq[9] = '{BTN_1, BTN_0, BTN_1, BTN_OR, BTN_0, BTN_0, BTN_1, BTN_EQUALS, BTN_CLEAR};
    logic [5:0] got[$];
    for (int k = 0; k < 9; k++) begin
      for (int c = 0; c < 20; c++) begin
        raw = (c < 10) ? 6'd1 << seq[k] : 6'h00;
        step();
        if (pulses != 0) got.push_back(pulses);
        checks++;
        if (pulses !== m_pulse || bus.Debounced !== m_deb) begin
          errors++;
          $display("FAIL sequence press %0d: pulse=%b deb=%b expected pulse=%b deb=%b",
                   k, pulses, bus.Debounced, m_pulse, m_deb);
        end
      end
    end
    checks++;
    if (got.size() != 9) begin
      errors++;
      $display("FAIL sequence_count: got %0d pulse cycles expected 9", got.size());
    end else
      for (int k = 0; k < 9; k++) begin
        checks++;
        if (got[k] !== 6'd1 << seq[k]) begin
          errors++;
          $display("FAIL sequence_order %0d: got %b expected %b", k, got[k], 6'd1 << seq[k]);
        end
      end
    quiet(12);
  endtask
  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 4) == 0) raw[$urandom_range(0, 5)] ^= 1'b1;
      step();
      checks++;
      if (pulses !== m_pulse || bus.Debounced !== m_deb || $countones(pulses) > 1) begin
        errors++;
        $display("FAIL random cycle %0d: raw=%b pulse=%b deb=%b expected pulse=%b deb=%b",
                 c, raw, pulses, bus.Debounced, m_pulse, m_deb);
      end
    end
    quiet(12);
  endtask
  initial begin
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_sequence();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
